// File: rtl/aexm_xmdu.sv
// aexm_xmdu: multi-cycle multiply/divide unit beside the aexm execute ALU.
// Define AEXM_XMDU_DIV_EN to build the radix-2 divider; otherwise IDIV/IDIVU act as reserved ops.
module aexm_xmdu #(
  parameter int unsigned DW      = 32,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          xmdu_start,
  input  logic [2:0]    xmdu_op,
  input  logic [DW-1:0] xmdu_opa,
  input  logic [DW-1:0] xmdu_opb,
  output logic          xmdu_busy,
  output logic          xmdu_done,
  output logic [DW-1:0] xmdu_result,
  output logic          xmdu_dz
);

  localparam int unsigned   PW        = 2 * DW;
  localparam int unsigned   ChunkW    = (PW + MUL_LAT - 1) / MUL_LAT;
  localparam logic [PW-1:0] ChunkMask = {PW{1'b1}} >> (PW - ChunkW);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd3;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StNop, StFin} state_e;

  state_e state_q, state_d;
  logic   accept;

  logic [2:0]    op_q;
  logic [PW-1:0] a_x_q, b_x_q, acc_q;
  logic [2:0]    mul_cnt_q;
  logic [DW-1:0] result_q;
  logic          dz_q;

  logic          a_sgn, b_sgn;
  logic [PW-1:0] a_ext, b_ext, a_src, b_src, acc_src, chunk, mul_sum;
  logic [2:0]    mul_k, mul_op;
  int unsigned   mul_sh;
  logic          mul_last;
  logic [DW-1:0] mul_res;

  logic          load_en, load_dz;
  logic [DW-1:0] load_res;

  assign accept = (state_q == StIdle) && xmdu_start;

  // Multiplier: operands are sign/zero-extended to 2*DW so one unsigned product covers every op.
  // One chunk of B is folded into the accumulator per edge; chunk 0 is taken at the accept edge.
  always_comb begin
    a_sgn = (xmdu_op == OpMulh) || (xmdu_op == OpMulhsu);
    b_sgn = (xmdu_op == OpMulh);
    a_ext = {{DW{a_sgn & xmdu_opa[DW-1]}}, xmdu_opa};
    b_ext = {{DW{b_sgn & xmdu_opb[DW-1]}}, xmdu_opb};
    if (state_q == StMul) begin
      mul_k   = mul_cnt_q;
      a_src   = a_x_q;
      b_src   = b_x_q;
      acc_src = acc_q;
      mul_op  = op_q;
    end else begin
      mul_k   = 3'd0;
      a_src   = a_ext;
      b_src   = b_ext;
      acc_src = '0;
      mul_op  = xmdu_op;
    end
    mul_sh   = 32'(mul_k) * ChunkW;
    chunk    = (b_src >> mul_sh) & ChunkMask;
    mul_sum  = acc_src + ((a_src * chunk) << mul_sh);
    mul_last = (mul_k == 3'(MUL_LAT - 1));
    mul_res  = (mul_op == OpMul) ? mul_sum[DW-1:0] : mul_sum[PW-1:DW];
  end

`ifdef AEXM_XMDU_DIV_EN
  localparam logic [2:0]  OpIdiv  = 3'd4;
  localparam logic [2:0]  OpIdivu = 3'd5;
  localparam int unsigned CntW    = $clog2(DW + 1);

  logic [DW-1:0]   rem_q, quo_q, dvs_q;
  logic            neg_q;
  logic [CntW-1:0] div_cnt_q;

  logic            div_signed, div_setup, div_fin, div_dz, ge;
  logic [DW-1:0]   a_mag, b_mag, rem_n, quo_n, div_res;
  logic [DW:0]     shifted, diff;

  // Restoring divider on magnitudes; count 0 is the setup cycle, counts 1..DW are iterations.
  always_comb begin
    div_signed = (op_q == OpIdiv);
    a_mag      = (div_signed && a_x_q[DW-1]) ? -a_x_q[DW-1:0] : a_x_q[DW-1:0];
    b_mag      = (div_signed && b_x_q[DW-1]) ? -b_x_q[DW-1:0] : b_x_q[DW-1:0];
    shifted    = {rem_q, quo_q[DW-1]};
    diff       = shifted - {1'b0, dvs_q};
    ge         = ~diff[DW];
    rem_n      = ge ? diff[DW-1:0] : shifted[DW-1:0];
    quo_n      = {quo_q[DW-2:0], ge};
    div_setup  = (div_cnt_q == '0);
    div_fin    = div_setup ? (a_mag == '0) : (div_cnt_q == CntW'(DW));
    div_dz     = div_setup;
    // Sign fix is folded into the load that enters the done cycle.
    div_res    = div_setup ? '0 : (neg_q ? -quo_n : quo_n);
  end

  always_ff @(posedge gclk) begin
    if (!grst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      div_cnt_q <= '0;
    end else if (gena) begin
      if (accept) begin
        div_cnt_q <= '0;
      end else if (state_q == StDiv) begin
        div_cnt_q <= div_cnt_q + 1'b1;
        if (div_setup) begin
          rem_q <= '0;
          quo_q <= b_mag;
          dvs_q <= a_mag;
          neg_q <= div_signed & (a_x_q[DW-1] ^ b_x_q[DW-1]);
        end else begin
          rem_q <= rem_n;
          quo_q <= quo_n;
        end
      end
    end
  end
`endif

  always_comb begin
    load_en  = 1'b0;
    load_res = '0;
    load_dz  = 1'b0;
    if ((accept || state_q == StMul) && !mul_op[2] && mul_last) begin
      load_en  = 1'b1;
      load_res = mul_res;
    end
    if (state_q == StNop) begin
      load_en = 1'b1;
    end
`ifdef AEXM_XMDU_DIV_EN
    if (state_q == StDiv && div_fin) begin
      load_en  = 1'b1;
      load_res = div_res;
      load_dz  = div_dz;
    end
`endif
  end

  always_ff @(posedge gclk) begin
    if (!grst) begin
      op_q      <= '0;
      a_x_q     <= '0;
      b_x_q     <= '0;
      acc_q     <= '0;
      mul_cnt_q <= '0;
      result_q  <= '0;
      dz_q      <= 1'b0;
    end else if (gena) begin
      if (accept) begin
        op_q      <= xmdu_op;
        a_x_q     <= a_ext;
        b_x_q     <= b_ext;
        acc_q     <= mul_sum;
        mul_cnt_q <= 3'd1;
      end else if (state_q == StMul) begin
        acc_q     <= mul_sum;
        mul_cnt_q <= mul_cnt_q + 3'd1;
      end
      if (load_en) begin
        result_q <= load_res;
        dz_q     <= load_dz;
      end
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst) begin
      state_q <= StIdle;
    end else if (gena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (xmdu_start) begin
          if (!xmdu_op[2]) begin
            state_d = (MUL_LAT == 1) ? StFin : StMul;
`ifdef AEXM_XMDU_DIV_EN
          end else if (xmdu_op == OpIdiv || xmdu_op == OpIdivu) begin
            state_d = StDiv;
`endif
          end else begin
            state_d = StNop;
          end
        end
      end
      StMul: begin
        if (mul_last) state_d = StFin;
      end
`ifdef AEXM_XMDU_DIV_EN
      StDiv: begin
        if (div_fin) state_d = StFin;
      end
`endif
      StNop:   state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    xmdu_busy = (state_q != StIdle);
    xmdu_done = (state_q == StFin);
  end

  assign xmdu_result = result_q;
  assign xmdu_dz     = dz_q;

endmodule

// File: tb/tb_aexm_xmdu.sv
// Directed self-checking bench for aexm_xmdu (DW=32, MUL_LAT=3); divider expectations follow
// whether AEXM_XMDU_DIV_EN is defined.
module tb_aexm_xmdu;

  localparam int unsigned DW      = 32;
  localparam int unsigned MUL_LAT = 3;
`ifdef AEXM_XMDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam int DivLat = DivEn ? DW + 2 : 2;

  logic          gclk = 1'b0;
  logic          grst, gena, start;
  logic [2:0]    op;
  logic [DW-1:0] opa, opb;
  logic          busy, done, dz;
  logic [DW-1:0] result;

  int total = 0;
  int bad   = 0;

  always #5 gclk = ~gclk;

  aexm_xmdu #(.DW(DW), .MUL_LAT(MUL_LAT)) dut (
    .gclk        (gclk),
    .grst        (grst),
    .gena        (gena),
    .xmdu_start  (start),
    .xmdu_op     (op),
    .xmdu_opa    (opa),
    .xmdu_opb    (opb),
    .xmdu_busy   (busy),
    .xmdu_done   (done),
    .xmdu_result (result),
    .xmdu_dz     (dz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, optionally freeze gena or keep start asserted.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] er, input logic edz,
                        input int elat, input int pause_at, input int pause_len,
                        input bit keep_start);
    int lat      = 0;
    int busy_cnt = 0;
    @(negedge gclk);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge gclk); #1;
    start = keep_start;
    op    = 3'd6;
    opa   = ~a;
    opb   = a ^ b;
    for (int k = 1; k <= 80; k++) begin
      if (pause_len != 0 && k == pause_at) gena = 1'b0;
      if (pause_len != 0 && k == pause_at + pause_len) gena = 1'b1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge gclk); #1;
    end
    gena = 1'b1;
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_dz"}, 64'(dz), 64'(edz));
    chk({tag, "_busycnt"}, 64'(busy_cnt), 64'(elat));
    @(posedge gclk); #1;
    start = 1'b0;
    chk({tag, "_done_clr"}, 64'(done), 64'd0);
    chk({tag, "_idle1"}, 64'(busy), 64'd0);
    @(posedge gclk); #1;
    chk({tag, "_idle2"}, 64'(busy), 64'd0);
  endtask

  initial begin
    grst  = 1'b0;
    gena  = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    opa   = '0;
    opb   = '0;
    repeat (2) @(posedge gclk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    @(negedge gclk);
    grst = 1'b1;

    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 3, 0, 0, 1'b0);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 3, 0, 0, 1'b0);
    run_op("mulhu_min", 3'd2, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 3, 0, 0, 1'b0);
    run_op("mulhsu_m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3, 0, 0, 1'b0);
    run_op("mulh_m1x5", 3'd1, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 1'b0, 3, 0, 0, 1'b0);
    run_op("mulhu_ffx5", 3'd2, 32'hFFFFFFFF, 32'd5, 32'd4, 1'b0, 3, 0, 0, 1'b0);
    run_op("mulhu_ffff", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3, 0, 0, 1'b0);
    run_op("mul_small", 3'd0, 32'h00012345, 32'h100, 32'h01234500, 1'b0, 3, 0, 0, 1'b0);
    run_op("rsv6", 3'd6, 32'd5, 32'd9, 32'd0, 1'b0, 2, 0, 0, 1'b0);
    run_op("mul_pre7", 3'd0, 32'd3, 32'd3, 32'd9, 1'b0, 3, 0, 0, 1'b0);
    run_op("rsv7", 3'd7, 32'd5, 32'd9, 32'd0, 1'b0, 2, 0, 0, 1'b0);

    run_op("idivu_100_7", 3'd5, 32'd7, 32'd100, DivEn ? 32'd14 : 32'd0, 1'b0, DivLat, 0, 0,
           1'b0);
    run_op("idiv_m100_7", 3'd4, 32'd7, 32'hFFFFFF9C, DivEn ? 32'hFFFFFFF2 : 32'd0, 1'b0, DivLat,
           0, 0, 1'b0);
    run_op("idiv_100_m7", 3'd4, 32'hFFFFFFF9, 32'd100, DivEn ? 32'hFFFFFFF2 : 32'd0, 1'b0,
           DivLat, 0, 0, 1'b0);
    run_op("idiv_m100_m7", 3'd4, 32'hFFFFFFF9, 32'hFFFFFF9C, DivEn ? 32'd14 : 32'd0, 1'b0,
           DivLat, 0, 0, 1'b0);
    run_op("idiv_ovf", 3'd4, 32'hFFFFFFFF, 32'h80000000, DivEn ? 32'h80000000 : 32'd0, 1'b0,
           DivLat, 0, 0, 1'b0);
    run_op("idivu_big", 3'd5, 32'h10, 32'hFFFFFFFF, DivEn ? 32'h0FFFFFFF : 32'd0, 1'b0, DivLat,
           0, 0, 1'b0);
    run_op("mul_pre_dz", 3'd0, 32'd4, 32'd4, 32'd16, 1'b0, 3, 0, 0, 1'b0);
    run_op("idiv_dz", 3'd4, 32'd0, 32'd100, 32'd0, DivEn, 2, 0, 0, 1'b0);
    repeat (3) @(posedge gclk);
    #1;
    chk("dz_held", 64'(dz), 64'(DivEn));
    run_op("idivu_dz", 3'd5, 32'd0, 32'd55, 32'd0, DivEn, 2, 0, 0, 1'b0);

    run_op("mul_frz", 3'd0, 32'h1234, 32'h10, 32'h12340, 1'b0, 8, 1, 5, 1'b0);
    run_op("mulhu_spam", 3'd2, 32'hFFFFFFFF, 32'h10, 32'hF, 1'b0, 3, 0, 0, 1'b1);
    run_op("idivu_spam", 3'd5, 32'd10, 32'd1000, DivEn ? 32'd100 : 32'd0, 1'b0, DivLat, 0, 0,
           1'b1);

    // Done pulse stretched by gena=0.
    @(negedge gclk);
    start = 1'b1;
    op    = 3'd0;
    opa   = 32'd3;
    opb   = 32'd5;
    @(posedge gclk); #1;
    start = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    chk("ext_done", 64'(done), 64'd1);
    gena = 1'b0;
    repeat (3) begin
      @(posedge gclk); #1;
      chk("ext_hold", 64'(done), 64'd1);
    end
    chk("ext_res", 64'(result), 64'd15);
    gena = 1'b1;
    @(posedge gclk); #1;
    chk("ext_clr", 64'(done), 64'd0);
    chk("ext_idle", 64'(busy), 64'd0);

    // Reset at divide iteration 10.
    @(negedge gclk);
    start = 1'b1;
    op    = 3'd4;
    opa   = 32'd7;
    opb   = 32'd100;
    @(posedge gclk); #1;
    start = 1'b0;
    repeat (10) @(posedge gclk);
    #1;
    chk("rdiv_busy", 64'(busy), 64'(DivEn));
    grst = 1'b0;
    @(posedge gclk); #1;
    chk("rdiv_busy0", 64'(busy), 64'd0);
    chk("rdiv_done0", 64'(done), 64'd0);
    chk("rdiv_res0", 64'(result), 64'd0);
    grst = 1'b1;
    run_op("mul_after_rdiv", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0, 3, 0, 0, 1'b0);

    // Reset mid-multiply beats gena=0 and start=1 in the same cycle.
    @(negedge gclk);
    start = 1'b1;
    op    = 3'd0;
    opa   = 32'd9;
    opb   = 32'd9;
    @(posedge gclk); #1;
    chk("rmul_busy", 64'(busy), 64'd1);
    gena = 1'b0;
    grst = 1'b0;
    @(posedge gclk); #1;
    chk("rmul_busy0", 64'(busy), 64'd0);
    chk("rmul_done0", 64'(done), 64'd0);
    chk("rmul_res0", 64'(result), 64'd0);
    grst  = 1'b1;
    gena  = 1'b1;
    start = 1'b0;
    @(posedge gclk); #1;
    chk("rmul_idle", 64'(busy), 64'd0);
    run_op("mulhsu_after_rmul", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 3, 0, 0,
           1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
